// File: rtl/tdm_demux_1_4_if.sv
// ---------------------------------------------------------------------------
// tdm_demux_1_4_if
// Bundles the signals of the 1-to-4 TDM demultiplexer.
//   din        : multiplexed sample for the current slot
//   din_valid  : din carries a slot beat this cycle
//   frame_sync : marks the current beat as slot 0 (qualified by din_valid)
//   ch_out     : latest sample per channel, channel k at [k*WIDTH +: WIDTH]
//   ch_valid   : one-cycle strobe per channel on update
//   frame_out  : atomic four-channel snapshot, same packing as ch_out
//   frame_done : one-cycle strobe when frame_out updates
//   locked     : high while locked to the frame marker
//   sync_err   : one-cycle strobe on a sync-position mismatch
// master = stream source / consumer side, slave = demultiplexer side.
// ---------------------------------------------------------------------------
interface tdm_demux_1_4_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0]   din;
    logic               din_valid;
    logic               frame_sync;
    logic [4*WIDTH-1:0] ch_out;
    logic [3:0]         ch_valid;
    logic [4*WIDTH-1:0] frame_out;
    logic               frame_done;
    logic               locked;
    logic               sync_err;

    modport master (
        output din, din_valid, frame_sync,
        input  ch_out, ch_valid, frame_out, frame_done, locked, sync_err
    );

    modport slave (
        input  din, din_valid, frame_sync,
        output ch_out, ch_valid, frame_out, frame_done, locked, sync_err
    );
endinterface

// File: rtl/tdm_demux_1_4.sv
// ---------------------------------------------------------------------------
// tdm_demux_1_4
// Receive side of a 4-to-1 time-division link. Locks to the frame-sync
// marker, steers each valid beat to its channel register, flags marker
// position errors and publishes a whole-frame snapshot when slot 3 lands.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : tdm_demux_1_4_if.slave (stream in, channel/frame/status out)
// ---------------------------------------------------------------------------
module tdm_demux_1_4 #(
    parameter int WIDTH = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    tdm_demux_1_4_if.slave     bus
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             r_state;
    logic [1:0]         r_slot;
    logic [4*WIDTH-1:0] r_ch_out;
    logic [3:0]         r_ch_valid;
    logic [4*WIDTH-1:0] r_frame_out;
    logic               r_frame_done;
    logic               r_sync_err;

    state_t             w_state_nxt;
    logic [1:0]         w_slot_nxt;
    logic [4*WIDTH-1:0] w_ch_out_nxt;
    logic [3:0]         w_ch_valid_nxt;
    logic [4*WIDTH-1:0] w_frame_out_nxt;
    logic               w_frame_done_nxt;
    logic               w_sync_err_nxt;
    logic               w_wr;
    logic [1:0]         w_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= HUNT;
            r_slot       <= '0;
            r_ch_out     <= '0;
            r_ch_valid   <= '0;
            r_frame_out  <= '0;
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_slot       <= w_slot_nxt;
            r_ch_out     <= w_ch_out_nxt;
            r_ch_valid   <= w_ch_valid_nxt;
            r_frame_out  <= w_frame_out_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_sync_err   <= w_sync_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_slot_nxt       = r_slot;
        w_ch_out_nxt     = r_ch_out;
        w_ch_valid_nxt   = '0;
        w_frame_out_nxt  = r_frame_out;
        w_frame_done_nxt = 1'b0;
        w_sync_err_nxt   = 1'b0;
        w_wr             = 1'b0;
        w_idx            = '0;

        if (bus.din_valid) begin
            unique case (r_state)
                HUNT: begin
                    if (bus.frame_sync) begin
                        w_wr        = 1'b1;
                        w_idx       = 2'd0;
                        w_slot_nxt  = 2'd1;
                        w_state_nxt = LOCKED;
                    end
                end
                LOCKED: begin
                    if (bus.frame_sync) begin
                        // Marker always realigns to slot 0; it is an error only if unexpected.
                        w_sync_err_nxt = (r_slot != 2'd0);
                        w_wr           = 1'b1;
                        w_idx          = 2'd0;
                        w_slot_nxt     = 2'd1;
                    end else if (r_slot == 2'd0) begin
                        // Missing marker: drop the beat and lose lock.
                        w_sync_err_nxt = 1'b1;
                        w_state_nxt    = HUNT;
                    end else begin
                        w_wr       = 1'b1;
                        w_idx      = r_slot;
                        w_slot_nxt = r_slot + 2'd1;
                        if (r_slot == 2'd3) begin
                            // Channel 3 comes straight from din so the snapshot is coherent.
                            w_frame_out_nxt  = {bus.din, r_ch_out[3*WIDTH-1:0]};
                            w_frame_done_nxt = 1'b1;
                        end
                    end
                end
                default: w_state_nxt = HUNT;
            endcase
        end

        for (int unsigned k = 0; k < 4; k++) begin
            if (w_wr && (w_idx == k[1:0])) begin
                w_ch_out_nxt[k*WIDTH +: WIDTH] = bus.din;
                w_ch_valid_nxt[k]              = 1'b1;
            end
        end
    end

    assign bus.ch_out     = r_ch_out;
    assign bus.ch_valid   = r_ch_valid;
    assign bus.frame_out  = r_frame_out;
    assign bus.frame_done = r_frame_done;
    assign bus.locked     = (r_state == LOCKED);
    assign bus.sync_err   = r_sync_err;

endmodule

// File: doc/tdm_demux_1_4.md
# tdm_demux_1_4

Time-division demultiplexer: takes a single serial slot stream carrying four channels interleaved round-robin (slot 0,1,2,3,0,…) and steers each beat to its own registered channel output. It is the receiving end of a 4-to-1 multiplexed link: the transmit side muxes in0..in3 onto one wire under a rotating select, and this block restores the four signals. It locks to a frame-sync marker, tracks the slot position with a counter, flags sync errors and presents a whole-frame snapshot.

## Interface

- WIDTH, 1, bits per channel sample.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- din  input  WIDTH  multiplexed sample for the current slot.
- din_valid  input  1  din carries a slot beat this cycle.
- frame_sync  input  1  qualified by din_valid; marks this beat as slot 0.
- ch_out  output  4*WIDTH  per-channel latest sample; channel k at bits [k*WIDTH +: WIDTH].
- ch_valid  output  4  one-cycle strobe; bit k set when channel k was updated.
- frame_out  output  4*WIDTH  atomic snapshot of all four channels; same packing as ch_out.
- frame_done  output  1  one-cycle strobe when frame_out updates.
- locked  output  1  high while in LOCKED state.
- sync_err  output  1  one-cycle strobe on a sync-position mismatch.

## Operation

- States: HUNT (after reset), LOCKED.
- HUNT: beats without frame_sync are dropped and update nothing. A beat with frame_sync is written to channel 0, slot counter set to 1, go LOCKED.
- LOCKED: each valid beat is written to channel slot, then slot increments mod 4 (3 -> 0 wrap).
- Sync check in LOCKED:
  - frame_sync on a beat with slot == 0: normal; no error.
  - frame_sync with slot != 0: sync_err pulses. The beat is written to channel 0, slot becomes 1. Stay LOCKED. No frame_done for the truncated frame.
  - slot == 0 beat without frame_sync: sync_err pulses, beat dropped, go HUNT. Only one missing marker is needed to drop lock.
- Frame assembly: when the slot-3 beat is written, frame_out gets channels 0–2 from ch_out and channel 3 from din in the same edge, and frame_done pulses. frame_out changes only at that point.
- din_valid low: no state change. Strobes are low. Gaps between beats of any length are allowed.
- ch_out holds its value between updates. Channels never written keep their reset value.

## Timing

- Reset (async assert, sync release) clears the following:
  - state = HUNT, slot = 0.
  - ch_out = 0, frame_out = 0.
  - ch_valid = 0, frame_done = 0, locked = 0, sync_err = 0.
- Latency is one cycle for every output:
  - A beat sampled at edge N appears on ch_out/ch_valid after edge N.
  - The slot-3 beat gives frame_out/frame_done after the same edge.
  - locked rises after the edge that samples the first frame_sync.
  - sync_err is valid after the edge that samples the offending beat.
- Back-to-back beats every cycle are supported at full rate. ch_valid is then one-hot, rotating each cycle.
- Reset asserted mid-frame clears everything immediately. After release the block is in HUNT; a partial frame is never reported.
- All strobes are exactly one cycle wide. They are never asserted on a cycle where din_valid was low at the preceding edge.

## Test plan

- Reset then lock:
  - Stimulus: rst_n low, then high. Then beats A,B,C,D (WIDTH=4: 1,2,3,4) every cycle, frame_sync on 1.
  - Required: locked=1 after the first beat; ch_valid 0001,0010,0100,1000; frame_out=0x4321 with frame_done one pulse.
- Hunt filtering:
  - Stimulus: three beats without frame_sync, then a synced frame 5,6,7,8.
  - Required: no ch_valid during the first three beats; frame_out=0x8765.
- Early sync:
  - Stimulus: frame_sync on the slot-2 beat of value 9.
  - Required: sync_err pulse; ch_out[3:0]=9; the next beat goes to channel 1; no frame_done for the broken frame.
- Missing sync:
  - Stimulus: slot-0 beat without frame_sync.
  - Required: sync_err pulse, locked=0, ch_out unchanged.
- Gapped stream and wrap:
  - Stimulus: beats with din_valid gaps of 0–5 cycles over 3 frames.
  - Required: correct channel steering; slot wraps 3 -> 0; three frame_done pulses.
- Async reset mid-frame:
  - Stimulus: rst_n low after slot 1 of a frame, between clock edges.
  - Required: all outputs 0 before the next edge; after release, a full synced frame is needed for frame_done.
